// File: rtl/mem_sum_master.sv
// Bus initiator that sums a block of consecutive memory words and writes the total back.
// Uses the same memread/memwrite/adr/writedata/memdata interface the core drives toward exmemory.
module mem_sum_master #(
    parameter int WIDTH   = 32,
    parameter int LENBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   base_adr,
    input  logic [LENBITS-1:0] count,
    input  logic [WIDTH-1:0]   dest_adr,
    input  logic [WIDTH-1:0]   memdata,
    output logic               memread,
    output logic               memwrite,
    output logic [WIDTH-1:0]   adr,
    output logic [WIDTH-1:0]   writedata,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   sum
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   cur_adr;
    logic [LENBITS-1:0] remaining;
    logic [WIDTH-1:0]   dst;
    logic [WIDTH-1:0]   acc;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    // State register plus the datapath registers advanced by the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_adr   <= '0;
            remaining <= '0;
            dst       <= '0;
            acc       <= '0;
            sum       <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_adr   <= base_adr & ALIGN_MASK;
                        dst       <= dest_adr & ALIGN_MASK;
                        remaining <= count;
                        acc       <= '0;
                        sum       <= '0;
                    end
                end
                READ: begin
                    acc       <= acc + memdata;
                    cur_adr   <= cur_adr + WIDTH'(4);
                    remaining <= remaining - LENBITS'(1);
                end
                WRITE:   sum <= acc;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start)
                    next_state = (count != '0) ? READ : WRITE;
            end
            READ: begin
                if (remaining == LENBITS'(1))
                    next_state = WRITE;
            end
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs depend only on state and registers, never on inputs directly.
    always_comb begin
        memread   = 1'b0;
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            READ: begin
                memread = 1'b1;
                adr     = cur_adr;
                busy    = 1'b1;
            end
            WRITE: begin
                memwrite  = 1'b1;
                adr       = dst;
                writedata = acc;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_sum_master.sv
// Self-checking bench for mem_sum_master with a word-array memory and a transfer-level reference model.
// Expected read addresses, sums and timing come from the block-sum rules, not from the RTL structure.
module tb_mem_sum_master;

    localparam int WIDTH   = 32;
    localparam int LENBITS = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   base_adr;
    logic [LENBITS-1:0] count;
    logic [WIDTH-1:0]   dest_adr;
    logic [WIDTH-1:0]   memdata;
    logic               memread;
    logic               memwrite;
    logic [WIDTH-1:0]   adr;
    logic [WIDTH-1:0]   writedata;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   sum;

    logic [31:0] ram      [0:255];
    logic [31:0] modelMem [0:255];
    logic        loadEn;
    logic [7:0]  loadIdx;
    logic [31:0] loadVal;
    int          writeCount = 0;
    int          compared   = 0;
    int          mismatched = 0;

    mem_sum_master #(.WIDTH(WIDTH), .LENBITS(LENBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_adr  (base_adr),
        .count     (count),
        .dest_adr  (dest_adr),
        .memdata   (memdata),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .busy      (busy),
        .done      (done),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    // Memory returns RAM[adr>>2] combinationally; the upper address bits fold onto a 256-word array.
    assign memdata = ram[adr[9:2]];

    always @(posedge clk) begin
        if (loadEn)
            ram[loadIdx] <= loadVal;
        else if (memwrite) begin
            ram[adr[9:2]] <= writedata;
            writeCount    <= writeCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setWord(input int idx, input logic [31:0] val);
        @(negedge clk);
        loadEn  = 1'b1;
        loadIdx = 8'(idx);
        loadVal = val;
        modelMem[idx] = val;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // Runs one transfer: start is held for 'hold' cycles, and an extra start with junk operands is
    // pulsed in cycle 'glitch' (0 = none). Every cycle of the transfer is compared to the model.
    task automatic applyStimulus(input logic [31:0] base, input int cnt, input logic [31:0] dest,
                                 input int hold, input int glitch);
        logic [31:0] aligned, dstAligned, expSum, a;
        int          writesBefore;
        aligned    = base & ~32'h3;
        dstAligned = dest & ~32'h3;
        expSum     = 32'h0;
        for (int i = 0; i < cnt; i++) begin
            a      = aligned + 32'(4 * i);
            expSum = expSum + modelMem[a[9:2]];
        end
        writesBefore = writeCount;
        @(negedge clk);
        base_adr = base;
        count    = LENBITS'(cnt);
        dest_adr = dest;
        start    = 1'b1;
        for (int c = 1; c <= cnt + 2; c++) begin
            @(negedge clk);
            if (c <= cnt) begin
                a = aligned + 32'(4 * (c - 1));
                checkOutput("readCtl", {memread, memwrite, busy, done}, 4'b1010);
                checkOutput("readAdr", adr, a);
            end else if (c == cnt + 1) begin
                checkOutput("writeCtl", {memread, memwrite, busy, done}, 4'b0110);
                checkOutput("writeAdr", adr, dstAligned);
                checkOutput("writeData", writedata, expSum);
            end else begin
                checkOutput("doneCtl", {memread, memwrite, busy, done}, 4'b0001);
                checkOutput("doneSum", sum, expSum);
            end
            start = (c < hold) || (c == glitch);
            if (c == glitch) begin
                base_adr = $urandom;
                count    = LENBITS'($urandom);
                dest_adr = $urandom;
            end
        end
        start = 1'b0;
        modelMem[dstAligned[9:2]] = expSum;
        @(negedge clk);
        checkOutput("idleCtl", {memread, memwrite, busy, done}, 4'b0000);
        checkOutput("idleAdr", adr, 32'h0);
        checkOutput("heldSum", sum, expSum);
        checkOutput("memResult", ram[dstAligned[9:2]], expSum);
        checkOutput("writeCount", 64'(writeCount - writesBefore), 64'd1);
    endtask

    initial begin
        int          writesBefore;
        logic [31:0] rb, rd;
        int          rc;
        reset    = 1'b1;
        start    = 1'b0;
        base_adr = '0;
        count    = '0;
        dest_adr = '0;
        loadEn   = 1'b0;
        loadIdx  = '0;
        loadVal  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstCtl", {memread, memwrite, busy, done}, 4'b0000);
        checkOutput("rstAdr", adr, 32'h0);
        checkOutput("rstWdata", writedata, 32'h0);
        checkOutput("rstSum", sum, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++)
            setWord(i, (i < 20) ? 32'(i + 1) : $urandom);

        $display("[TB] block of 1..20");
        applyStimulus(32'h0, 20, 32'd252, 1, 0);
        checkOutput("sum210", sum, 32'd210);

        $display("[TB] zero count");
        applyStimulus(32'h0, 0, 32'd16, 1, 0);
        checkOutput("sumZero", sum, 32'h0);

        $display("[TB] overflow");
        for (int i = 100; i < 103; i++) setWord(i, 32'hFFFF_FFFF);
        applyStimulus(32'd400, 3, 32'd800, 1, 0);
        checkOutput("sumOverflow", sum, 32'hFFFF_FFFD);

        $display("[TB] address wrap and misaligned base");
        applyStimulus(32'hFFFF_FFF8, 4, 32'd900, 1, 0);
        applyStimulus(32'h0000_0013, 3, 32'd901, 1, 0);

        $display("[TB] start during READ ignored, dest inside read range");
        applyStimulus(32'h0, 20, 32'd8, 1, 7);

        $display("[TB] start held three cycles, then a fresh transfer");
        applyStimulus(32'd40, 5, 32'd500, 3, 0);
        applyStimulus(32'd60, 4, 32'd504, 1, 0);

        $display("[TB] start together with reset");
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("startInReset", {memread, memwrite, busy, done}, 4'b0000);

        $display("[TB] reset during READ aborts");
        writesBefore = writeCount;
        @(negedge clk);
        base_adr = 32'h0;
        count    = 8'd10;
        dest_adr = 32'd960;
        start    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("preAbortRead", {memread, memwrite, busy, done}, 4'b1010);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abortCtl", {memread, memwrite, busy, done}, 4'b0000);
        checkOutput("abortAdr", adr, 32'h0);
        checkOutput("abortSum", sum, 32'h0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("abortNoWrite", 64'(writeCount - writesBefore), 64'd0);
        checkOutput("abortIdle", {memread, memwrite, busy, done}, 4'b0000);
        checkOutput("abortMem", ram[240], modelMem[240]);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 10; t++) begin
            rb = $urandom;
            rd = $urandom;
            rc = $urandom_range(0, 12);
            applyStimulus(rb, rc, rd, $urandom_range(1, 2), (rc > 0) ? $urandom_range(0, rc) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
